// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg
// Shared definitions for the data-memory port arbiter: FSM state encoding,
// funct3 access codes, alignment masks and the misalignment helper.
// No ports (package).
package dmem_port_arbiter_pkg;

    // Arbiter FSM: IDLE accepts requests, RESP returns one cycle of load data.
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

    // funct3 access codes as seen on the load/store path.
    localparam logic [2:0] ACC_BYTE   = 3'b000;
    localparam logic [2:0] ACC_HALF   = 3'b001;
    localparam logic [2:0] ACC_WORD   = 3'b010;
    localparam logic [2:0] ACC_BYTE_U = 3'b100;
    localparam logic [2:0] ACC_HALF_U = 3'b101;

    // Low address bits that must be zero for each access size.
    localparam logic [1:0] BYTE_ALIGN_MASK = 2'b00;
    localparam logic [1:0] HALF_ALIGN_MASK = 2'b01;
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    // Codes that are neither byte nor half are held to word alignment, so an
    // undefined code can never slip through on a weaker check.
    function automatic logic is_misaligned(input logic [2:0] access,
                                           input logic [1:0] addr_lsb);
        logic [1:0] mask;
        case (access)
            ACC_BYTE, ACC_BYTE_U: mask = BYTE_ALIGN_MASK;
            ACC_HALF, ACC_HALF_U: mask = HALF_ALIGN_MASK;
            ACC_WORD:             mask = WORD_ALIGN_MASK;
            default:              mask = WORD_ALIGN_MASK;
        endcase
        return (addr_lsb & mask) != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr.sv
// rr_arbiter2
// Two-way round-robin pick with its priority pointer.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   req[1:0]   requests competing this cycle
//   advance    a grant is being taken; move the pointer
//   grant[1:0] one-hot (or zero) winner, combinational
module rr_arbiter2 #(
    parameter int RR_INIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    localparam logic INIT_PTR = (RR_INIT != 0);

    // Index of the requester that wins a tie.
    logic prio;

    // A lone requester always wins; on a tie the pointer decides.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After a grant the tie goes to the other requester: if 0 was granted,
    // grant[0] is 1 and priority passes to 1, and vice versa.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= INIT_PTR;
        end else if (advance) begin
            prio <= grant[0];
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares one data-memory port between the core load/store path (requester 0)
// and the edgcol engine (requester 1). Stores complete in the grant cycle;
// loads return data one cycle later, during which no new grant is issued.
// Misaligned accesses are accepted and rejected with err in the same cycle.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqX/weX/addrX/wdataX/accessX   request side of requester X
//   gntX/rvalidX/rdataX/errX        response side of requester X
//   memRdEna/memWrEna/memAddr/memWrData/memAccess   memory command
//   memRdData                memory read data, one cycle after memRdEna
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int N       = 32,
    parameter int RR_INIT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         we0,
    input  logic [N-1:0] addr0,
    input  logic [N-1:0] wdata0,
    input  logic [2:0]   access0,
    input  logic         req1,
    input  logic         we1,
    input  logic [N-1:0] addr1,
    input  logic [N-1:0] wdata1,
    input  logic [2:0]   access1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         rvalid0,
    output logic         rvalid1,
    output logic [N-1:0] rdata0,
    output logic [N-1:0] rdata1,
    output logic         err0,
    output logic         err1,
    output logic         memRdEna,
    output logic         memWrEna,
    output logic [N-1:0] memAddr,
    output logic [N-1:0] memWrData,
    output logic [2:0]   memAccess,
    input  logic [N-1:0] memRdData
);

    arb_state_t   state;
    logic         owner;
    logic [N-1:0] rdata0_q;
    logic [N-1:0] rdata1_q;

    logic [1:0]   arb_req;
    logic [1:0]   arb_grant;
    logic         advance;
    logic         sel;
    logic         sel_we;
    logic [N-1:0] sel_addr;
    logic [N-1:0] sel_wdata;
    logic [2:0]   sel_access;
    logic         misaligned;
    logic         resp_active;

    // Requests only compete in IDLE; reset wins over any request.
    assign arb_req = (state == IDLE && !rst) ? {req1, req0} : 2'b00;
    assign advance = |arb_grant;

    rr_arbiter2 #(
        .RR_INIT(RR_INIT)
    ) u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req),
        .advance(advance),
        .grant  (arb_grant)
    );

    assign sel        = arb_grant[1];
    assign sel_we     = sel ? we1     : we0;
    assign sel_addr   = sel ? addr1   : addr0;
    assign sel_wdata  = sel ? wdata1  : wdata0;
    assign sel_access = sel ? access1 : access0;
    assign misaligned = is_misaligned(sel_access, sel_addr[1:0]);

    // Grant-cycle command: the memory bus carries the winner's request only
    // when it is aligned; otherwise the grant is paired with err and the bus
    // stays quiet.
    always_comb begin
        gnt0      = arb_grant[0];
        gnt1      = arb_grant[1];
        err0      = 1'b0;
        err1      = 1'b0;
        memRdEna  = 1'b0;
        memWrEna  = 1'b0;
        memAddr   = '0;
        memWrData = '0;
        memAccess = 3'b000;
        if (advance) begin
            if (misaligned) begin
                err0 = arb_grant[0];
                err1 = arb_grant[1];
            end else begin
                memAddr   = sel_addr;
                memWrData = sel_wdata;
                memAccess = sel_access;
                memWrEna  = sel_we;
                memRdEna  = !sel_we;
            end
        end
    end

    // Load data is forwarded straight from memory in the RESP cycle; the
    // registered copy keeps rdata stable afterwards. Reset suppresses a
    // pending response so an aborted load never pulses rvalid.
    assign resp_active = (state == RESP) && !rst;
    assign rvalid0     = resp_active && !owner;
    assign rvalid1     = resp_active && owner;
    assign rdata0      = rst ? '0 : (rvalid0 ? memRdData : rdata0_q);
    assign rdata1      = rst ? '0 : (rvalid1 ? memRdData : rdata1_q);

    // FSM: an aligned granted load records its owner and moves to RESP;
    // RESP captures the returned data and always falls back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (advance && !misaligned && !sel_we) begin
                        state <= RESP;
                        owner <= sel;
                    end
                end
                RESP: begin
                    if (owner) begin
                        rdata1_q <= memRdData;
                    end else begin
                        rdata0_q <= memRdData;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
// Directed bench for dmem_port_arbiter. A transaction-level model predicts
// every output on every cycle; directed scenarios also pin hand-computed values.
module tb_dmem_port_arbiter;

    localparam int N       = 32;
    localparam int RR_INIT = 0;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [N-1:0]  addr0, wdata0, addr1, wdata1;
    logic [2:0]    access0, access1;
    logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [N-1:0]  rdata0, rdata1;
    logic          memRdEna, memWrEna;
    logic [N-1:0]  memAddr, memWrData, memRdData;
    logic [2:0]    memAccess;

    int checks = 0;
    int errors = 0;
    bit compareOn = 1'b0;

    // Model state: outstanding load, its owner, tie-break holder, last load data.
    bit            mBusy = 1'b0;
    int            mOwner = 0;
    int            mPrio = RR_INIT;
    logic [31:0]   mRdata [2] = '{32'h0, 32'h0};

    dmem_port_arbiter #(
        .N(N),
        .RR_INIT(RR_INIT)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .access0(access0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .access1(access1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .memRdEna(memRdEna), .memWrEna(memWrEna), .memAddr(memAddr),
        .memWrData(memWrData), .memAccess(memAccess), .memRdData(memRdData)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Number of bytes touched by an access code; undefined codes count as word.
    function automatic int accessBytes(input logic [2:0] c);
        case (c)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Predict all outputs from the current inputs at the falling edge, compare,
    // then advance the model to what the next rising edge must produce.
    always @(negedge clk) begin : compare_proc
        bit          r [2];
        bit          w [2];
        logic [31:0] a [2];
        logic [31:0] d [2];
        logic [2:0]  c [2];
        bit          eGnt [2];
        bit          eErr [2];
        bit          eRv [2];
        logic [31:0] eRdat [2];
        bit          eRd, eWr;
        logic [31:0] eAddr, eWd;
        logic [2:0]  eAcc;
        int          win;
        if (compareOn) begin
            r = '{req0, req1};
            w = '{we0, we1};
            a = '{addr0, addr1};
            d = '{wdata0, wdata1};
            c = '{access0, access1};
            eGnt = '{1'b0, 1'b0};
            eErr = '{1'b0, 1'b0};
            eRv  = '{1'b0, 1'b0};
            eRdat = mRdata;
            eRd = 1'b0; eWr = 1'b0;
            eAddr = 32'h0; eWd = 32'h0; eAcc = 3'b000;
            if (rst) begin
                eRdat = '{32'h0, 32'h0};
                mRdata = '{32'h0, 32'h0};
                mBusy = 1'b0;
                mPrio = RR_INIT;
            end else if (mBusy) begin
                eRv[mOwner] = 1'b1;
                eRdat[mOwner] = memRdData;
                mRdata[mOwner] = memRdData;
                mBusy = 1'b0;
            end else begin
                win = -1;
                if (r[0] && r[1]) win = mPrio;
                else if (r[0])    win = 0;
                else if (r[1])    win = 1;
                if (win >= 0) begin
                    eGnt[win] = 1'b1;
                    mPrio = 1 - win;
                    if ((a[win] % accessBytes(c[win])) != 0) begin
                        eErr[win] = 1'b1;
                    end else begin
                        eAddr = a[win];
                        eWd   = d[win];
                        eAcc  = c[win];
                        if (w[win]) begin
                            eWr = 1'b1;
                        end else begin
                            eRd = 1'b1;
                            mBusy = 1'b1;
                            mOwner = win;
                        end
                    end
                end
            end
            checkOutput("model gnt0", {31'h0, gnt0}, {31'h0, eGnt[0]});
            checkOutput("model gnt1", {31'h0, gnt1}, {31'h0, eGnt[1]});
            checkOutput("model err0", {31'h0, err0}, {31'h0, eErr[0]});
            checkOutput("model err1", {31'h0, err1}, {31'h0, eErr[1]});
            checkOutput("model rvalid0", {31'h0, rvalid0}, {31'h0, eRv[0]});
            checkOutput("model rvalid1", {31'h0, rvalid1}, {31'h0, eRv[1]});
            checkOutput("model rdata0", rdata0, eRdat[0]);
            checkOutput("model rdata1", rdata1, eRdat[1]);
            checkOutput("model memRdEna", {31'h0, memRdEna}, {31'h0, eRd});
            checkOutput("model memWrEna", {31'h0, memWrEna}, {31'h0, eWr});
            checkOutput("model memAddr", memAddr, eAddr);
            checkOutput("model memWrData", memWrData, eWd);
            checkOutput("model memAccess", {29'h0, memAccess}, {29'h0, eAcc});
        end
    end

    // Drive one requester's fields for the current cycle.
    task automatic applyStimulus(input int port, input bit r, input bit w,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [2:0] c);
        if (port == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d; access0 = c;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d; access1 = c;
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        memRdData = 32'h0;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 3'b000);
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 3'b000);
        compareOn = 1'b1;

        // Reset state
        stepCycle();
        stepCycle();
        settle();
        checkOutput("reset gnt0", {31'h0, gnt0}, 32'h0);
        checkOutput("reset rdata0", rdata0, 32'h0);
        checkOutput("reset memWrEna", {31'h0, memWrEna}, 32'h0);

        // Solo store from requester 0
        stepCycle();
        rst = 1'b0;
        applyStimulus(0, 1, 1, 32'h10, 32'hDEADBEEF, 3'b010);
        settle();
        checkOutput("store gnt0", {31'h0, gnt0}, 32'h1);
        checkOutput("store memWrEna", {31'h0, memWrEna}, 32'h1);
        checkOutput("store memAddr", memAddr, 32'h10);
        checkOutput("store memWrData", memWrData, 32'hDEADBEEF);

        stepCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 3'b000);
        settle();
        checkOutput("idle memAddr", memAddr, 32'h0);

        // Solo load from requester 1
        stepCycle();
        applyStimulus(1, 1, 0, 32'h20, 32'h0, 3'b010);
        settle();
        checkOutput("load gnt1", {31'h0, gnt1}, 32'h1);
        checkOutput("load memRdEna", {31'h0, memRdEna}, 32'h1);
        checkOutput("load memAddr", memAddr, 32'h20);

        stepCycle();
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 3'b000);
        memRdData = 32'h12345678;
        settle();
        checkOutput("load rvalid1", {31'h0, rvalid1}, 32'h1);
        checkOutput("load rdata1", rdata1, 32'h12345678);
        checkOutput("load rvalid0", {31'h0, rvalid0}, 32'h0);

        stepCycle();
        memRdData = 32'h0;
        settle();
        checkOutput("hold rvalid1", {31'h0, rvalid1}, 32'h0);
        checkOutput("hold rdata1", rdata1, 32'h12345678);

        // Contention with continuous stores after reset
        stepCycle();
        rst = 1'b1;
        settle();
        stepCycle();
        rst = 1'b0;
        applyStimulus(0, 1, 1, 32'h100, 32'hA0, 3'b010);
        applyStimulus(1, 1, 1, 32'h200, 32'hB0, 3'b010);
        for (int i = 0; i < 4; i++) begin
            settle();
            checkOutput("contention gnt0", {31'h0, gnt0}, (i % 2 == 0) ? 32'h1 : 32'h0);
            checkOutput("contention gnt1", {31'h0, gnt1}, (i % 2 == 1) ? 32'h1 : 32'h0);
            stepCycle();
            applyStimulus(0, 1, 1, 32'h104 + 32'(i * 4), 32'hA1 + 32'(i), 3'b010);
            applyStimulus(1, 1, 1, 32'h204 + 32'(i * 4), 32'hB1 + 32'(i), 3'b010);
        end
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 3'b000);
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 3'b000);

        // Misaligned word load
        applyStimulus(0, 1, 0, 32'h13, 32'h0, 3'b010);
        settle();
        checkOutput("misaligned gnt0", {31'h0, gnt0}, 32'h1);
        checkOutput("misaligned err0", {31'h0, err0}, 32'h1);
        checkOutput("misaligned memRdEna", {31'h0, memRdEna}, 32'h0);
        checkOutput("misaligned memAddr", memAddr, 32'h0);

        // Next cycle still IDLE: misaligned half store is granted and rejected
        stepCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 3'b000);
        applyStimulus(1, 1, 1, 32'h21, 32'h55, 3'b001);
        settle();
        checkOutput("after misaligned rvalid0", {31'h0, rvalid0}, 32'h0);
        checkOutput("half misaligned gnt1", {31'h0, gnt1}, 32'h1);
        checkOutput("half misaligned err1", {31'h0, err1}, 32'h1);
        checkOutput("half misaligned memWrEna", {31'h0, memWrEna}, 32'h0);

        // Byte store at an odd address is legal
        stepCycle();
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 3'b000);
        applyStimulus(0, 1, 1, 32'h23, 32'h77, 3'b100);
        settle();
        checkOutput("byte store memWrEna", {31'h0, memWrEna}, 32'h1);
        checkOutput("byte store err0", {31'h0, err0}, 32'h0);
        checkOutput("byte store memAccess", {29'h0, memAccess}, 32'h4);

        // Aligned half load
        stepCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 3'b000);
        applyStimulus(1, 1, 0, 32'h22, 32'h0, 3'b101);
        settle();
        checkOutput("half load memRdEna", {31'h0, memRdEna}, 32'h1);
        checkOutput("half load gnt1", {31'h0, gnt1}, 32'h1);

        stepCycle();
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 3'b000);
        memRdData = 32'h0000BEEF;
        settle();
        checkOutput("half load rvalid1", {31'h0, rvalid1}, 32'h1);
        checkOutput("half load rdata1", rdata1, 32'h0000BEEF);

        // Load back-pressure: both requesters keep issuing loads
        stepCycle();
        rst = 1'b1;
        memRdData = 32'h0;
        settle();
        stepCycle();
        rst = 1'b0;
        applyStimulus(0, 1, 0, 32'h40, 32'h0, 3'b010);
        applyStimulus(1, 1, 0, 32'h44, 32'h0, 3'b010);
        settle();
        checkOutput("bp T gnt0", {31'h0, gnt0}, 32'h1);
        checkOutput("bp T gnt1", {31'h0, gnt1}, 32'h0);

        stepCycle();
        applyStimulus(0, 1, 0, 32'h48, 32'h0, 3'b010);
        memRdData = 32'h11111111;
        settle();
        checkOutput("bp T+1 gnt0", {31'h0, gnt0}, 32'h0);
        checkOutput("bp T+1 gnt1", {31'h0, gnt1}, 32'h0);
        checkOutput("bp T+1 rvalid0", {31'h0, rvalid0}, 32'h1);
        checkOutput("bp T+1 rdata0", rdata0, 32'h11111111);

        stepCycle();
        memRdData = 32'h0;
        settle();
        checkOutput("bp T+2 gnt1", {31'h0, gnt1}, 32'h1);
        checkOutput("bp T+2 gnt0", {31'h0, gnt0}, 32'h0);

        stepCycle();
        applyStimulus(1, 1, 0, 32'h4C, 32'h0, 3'b010);
        memRdData = 32'h22222222;
        settle();
        checkOutput("bp T+3 rvalid1", {31'h0, rvalid1}, 32'h1);
        checkOutput("bp T+3 gnt0", {31'h0, gnt0}, 32'h0);
        checkOutput("bp T+3 rdata1", rdata1, 32'h22222222);

        stepCycle();
        memRdData = 32'h0;
        settle();
        checkOutput("bp T+4 gnt0", {31'h0, gnt0}, 32'h1);
        checkOutput("bp T+4 memAddr", memAddr, 32'h48);

        stepCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 3'b000);
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 3'b000);
        memRdData = 32'h33333333;
        settle();
        checkOutput("bp T+5 rvalid0", {31'h0, rvalid0}, 32'h1);
        checkOutput("bp T+5 rdata0", rdata0, 32'h33333333);

        // Reset in the response cycle aborts the load
        stepCycle();
        memRdData = 32'h0;
        applyStimulus(0, 1, 0, 32'h50, 32'h0, 3'b010);
        settle();
        checkOutput("abort load gnt0", {31'h0, gnt0}, 32'h1);
        checkOutput("abort load memRdEna", {31'h0, memRdEna}, 32'h1);

        stepCycle();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 3'b000);
        applyStimulus(1, 1, 1, 32'h60, 32'h66, 3'b010);
        memRdData = 32'hCAFEF00D;
        settle();
        checkOutput("abort rvalid0", {31'h0, rvalid0}, 32'h0);
        checkOutput("abort gnt1 under reset", {31'h0, gnt1}, 32'h0);
        checkOutput("abort rdata0", rdata0, 32'h0);

        stepCycle();
        rst = 1'b0;
        memRdData = 32'h0;
        applyStimulus(0, 1, 1, 32'h70, 32'h77, 3'b010);
        settle();
        checkOutput("post-reset pointer gnt0", {31'h0, gnt0}, 32'h1);
        checkOutput("post-reset pointer gnt1", {31'h0, gnt1}, 32'h0);
        checkOutput("post-reset rvalid0", {31'h0, rvalid0}, 32'h0);

        stepCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 3'b000);
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 3'b000);
        settle();
        checkOutput("quiet rvalid0", {31'h0, rvalid0}, 32'h0);
        checkOutput("quiet rdata0", rdata0, 32'h0);

        stepCycle();
        compareOn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
